// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the reduced RISC-V core: sequences fetch/decode/exec/mem/wb and handshakes with memory.
// Build option: define ILLEGAL_TRAP_EN to trap on unknown opcodes (default: unknown opcodes execute as NOPs).
//
// state  | meaning
// FETCH  | request instruction word, latch IR on mem_ready
// DECODE | decode latched opcode, immediate select valid
// EXEC   | ALU op, branch/jump resolution
// MEM    | load/store access, waits on mem_ready
// WB     | single-cycle register-file write
// TRAP   | illegal opcode, everything idle until reset
module multicycle_control #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int ALU_CTRL_W    = 3,
    parameter int MAX_WAIT      = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] instr,
    input  logic                     EQ,
    input  logic                     mem_ready,
    output logic                     mem_req,
    output logic                     MemWrite,
    output logic                     IRWrite,
    output logic                     PCWrite,
    output logic                     PCsrc,
    output logic                     RegWrite,
    output logic [ALU_CTRL_W-1:0]    ALUctrl,
    output logic                     ALUsrc,
    output logic [2:0]               ImmSrc,
    output logic [1:0]               ResultSrc,
    output logic                     mem_timeout,
    output logic [2:0]               state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [7:0] WAIT_LAST  = 8'(MAX_WAIT - 1);

    state_t     state_q;
    logic [6:0] opc_q;
    logic [2:0] fn3_q;
    logic       fn7b5_q;
    logic [7:0] wait_q;
    logic       timeout_q;
    logic       drop_q;

    logic is_opimm, is_op, is_load, is_store, is_branch, is_jal, is_lui;
    logic wait_state, tmo_hit, br_taken;
    logic [2:0] alu_fn3, alu_sel, imm_sel, alu3;
    logic asrc_sel;
    logic unused_instr;

    assign unused_instr = ^{instr[ADDRESS_WIDTH-1:31], instr[29:15], instr[11:7]};

    assign is_opimm  = (opc_q == OPC_OPIMM);
    assign is_op     = (opc_q == OPC_OP);
    assign is_load   = (opc_q == OPC_LOAD);
    assign is_store  = (opc_q == OPC_STORE);
    assign is_branch = (opc_q == OPC_BRANCH);
    assign is_jal    = (opc_q == OPC_JAL);
    assign is_lui    = (opc_q == OPC_LUI);

    // drop_q idles mem_req for one cycle after a timeout so the aborted request is visibly withdrawn
    assign wait_state = ((state_q == S_FETCH) && !drop_q) || (state_q == S_MEM);
    assign tmo_hit    = wait_state && !mem_ready && (wait_q == WAIT_LAST);
    assign br_taken   = is_branch && (((fn3_q == 3'b000) && EQ) || ((fn3_q == 3'b001) && !EQ));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            opc_q     <= '0;
            fn3_q     <= '0;
            fn7b5_q   <= 1'b0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            if (tmo_hit) begin
                state_q   <= S_FETCH;
                wait_q    <= '0;
                timeout_q <= 1'b1;
                drop_q    <= 1'b1;
            end else begin
                wait_q <= (wait_state && !mem_ready) ? wait_q + 8'd1 : 8'd0;
                case (state_q)
                    S_FETCH: begin
                        if (!drop_q && mem_ready) begin
                            opc_q   <= instr[6:0];
                            fn3_q   <= instr[14:12];
                            fn7b5_q <= instr[30];
                            state_q <= S_DECODE;
                        end
                    end
                    S_DECODE: state_q <= S_EXEC;
                    S_EXEC: begin
                        if (is_load || is_store)
                            state_q <= S_MEM;
                        else if (is_opimm || is_op || is_jal || is_lui)
                            state_q <= S_WB;
                        else if (is_branch)
                            state_q <= S_FETCH;
                        else
`ifdef ILLEGAL_TRAP_EN
                            state_q <= S_TRAP;
`else
                            state_q <= S_FETCH;
`endif
                    end
                    S_MEM: begin
                        if (mem_ready)
                            state_q <= is_load ? S_WB : S_FETCH;
                    end
                    S_WB:    state_q <= S_FETCH;
                    S_TRAP:  state_q <= S_TRAP;
                    default: state_q <= S_FETCH;
                endcase
            end
        end
    end

    always_comb begin
        alu_fn3 = 3'b000;
        case (fn3_q)
            3'b000: alu_fn3 = (is_op && fn7b5_q) ? 3'b001 : 3'b000;
            3'b001: alu_fn3 = 3'b110;
            3'b010: alu_fn3 = 3'b101;
            3'b011: alu_fn3 = 3'b101;
            3'b100: alu_fn3 = 3'b100;
            3'b101: alu_fn3 = 3'b111;
            3'b110: alu_fn3 = 3'b011;
            3'b111: alu_fn3 = 3'b010;
            default: alu_fn3 = 3'b000;
        endcase
        alu_sel  = (is_opimm || is_op) ? alu_fn3 : (is_branch ? 3'b001 : 3'b000);
        asrc_sel = is_opimm || is_load || is_store;
        imm_sel  = is_store ? 3'b001 : is_branch ? 3'b010 : is_jal ? 3'b011 : is_lui ? 3'b100 : 3'b000;
    end

    always_comb begin
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCsrc     = 1'b0;
        RegWrite  = 1'b0;
        ALUsrc    = 1'b0;
        ImmSrc    = 3'b000;
        ResultSrc = 2'b00;
        alu3      = 3'b000;
        case (state_q)
            S_FETCH: begin
                mem_req = !drop_q;
                IRWrite = !drop_q && mem_ready;
                PCWrite = !drop_q && mem_ready;
            end
            S_EXEC: begin
                PCWrite = br_taken || is_jal;
                PCsrc   = br_taken || is_jal;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                MemWrite = is_store;
            end
            S_WB: begin
                RegWrite  = 1'b1;
                ResultSrc = is_load ? 2'b01 : is_jal ? 2'b10 : is_lui ? 2'b11 : 2'b00;
            end
            default: ;
        endcase
        if ((state_q == S_DECODE) || (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB))
            ImmSrc = imm_sel;
        if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
            alu3   = alu_sel;
            ALUsrc = asrc_sel;
        end
        // state_q already reads FETCH during reset; keep the bus quiet until release
        if (!rst_n) begin
            mem_req = 1'b0;
            IRWrite = 1'b0;
            PCWrite = 1'b0;
        end
    end

    assign ALUctrl     = ALU_CTRL_W'(alu3);
    assign mem_timeout = timeout_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected control vectors are queued with the stimulus
// and compared (masked to the outputs defined in each state) as the DUT steps through each instruction.
module tb_multicycle_control;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        EQ = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, MemWrite, IRWrite, PCWrite, PCsrc, RegWrite, ALUsrc, mem_timeout;
    logic [2:0]  ALUctrl, ImmSrc, state_o;
    logic [1:0]  ResultSrc;

    multicycle_control #(.ADDRESS_WIDTH(32), .ALU_CTRL_W(3), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .EQ(EQ), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCsrc(PCsrc), .RegWrite(RegWrite), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc),
        .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .mem_timeout(mem_timeout), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // vector: state[18:16] req mw irw pcw pcs rw alu[9:7] asrc imm[5:3] res[2:1] tmo
    localparam logic [18:0] M_ALL  = '1;
    localparam logic [18:0] M_BASE = 19'b111_1_1_1_1_0_1_000_0_000_00_1;
    localparam logic [18:0] M_PCS  = 19'h1 << 11;
    localparam logic [18:0] M_ALU  = 19'h7 << 7;
    localparam logic [18:0] M_ASRC = 19'h1 << 6;
    localparam logic [18:0] M_IMM  = 19'h7 << 3;
    localparam logic [18:0] M_RES  = 19'h3 << 1;

    typedef struct {
        logic        rdy;
        logic        eq;
        logic [31:0] ins;
        logic [18:0] exp;
        logic [18:0] msk;
    } step_t;

    step_t sq[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_pass = 0;
    logic  tmo_exp = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [18:0] pack_outputs();
        return {state_o, mem_req, MemWrite, IRWrite, PCWrite, PCsrc, RegWrite,
                ALUctrl, ALUsrc, ImmSrc, ResultSrc, mem_timeout};
    endfunction

    function automatic logic [18:0] rec(input logic [2:0] st, input logic req, input logic mw,
                                        input logic irw, input logic pcw, input logic pcs, input logic rw,
                                        input logic [2:0] alu, input logic asrc, input logic [2:0] imm,
                                        input logic [1:0] res);
        return {st, req, mw, irw, pcw, pcs, rw, alu, asrc, imm, res, tmo_exp};
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] fn3);
        case (fn3)
            3'b000: return 3'b000;
            3'b001: return 3'b110;
            3'b010: return 3'b101;
            3'b011: return 3'b101;
            3'b100: return 3'b100;
            3'b101: return 3'b111;
            3'b110: return 3'b011;
            default: return 3'b010;
        endcase
    endfunction

    task automatic push(input logic rdy, input logic eq, input logic [31:0] ins,
                        input logic [18:0] exp, input logic [18:0] msk, input string tag);
        step_t s;
        s.rdy = rdy; s.eq = eq; s.ins = ins; s.exp = exp; s.msk = msk;
        sq.push_back(s);
        tag_q.push_back(tag);
    endtask

    // stop_mem: leave the instruction parked in MEM after mwait not-ready cycles
    task automatic gen_instr(input string nm, input logic [31:0] w, input logic eq,
                             input int fwait, input int mwait, input bit stop_mem);
        logic [6:0] opc;
        logic [2:0] fn3, alu, imm;
        logic [1:0] res;
        logic       asrc, pcw;
        bit         imm_v, alu_v, ld, st, wb;
        int         c;
        opc = w[6:0]; fn3 = w[14:12];
        alu = 3'b000; imm = 3'b000; res = 2'b00; asrc = 1'b0; pcw = 1'b0;
        imm_v = 0; alu_v = 0; ld = 0; st = 0; wb = 0; c = 1;
        case (opc)
            7'b0010011: begin alu = alu_of(fn3); asrc = 1; imm_v = 1; alu_v = 1; wb = 1; end
            7'b0110011: begin alu = (fn3 == 3'b000 && w[30]) ? 3'b001 : alu_of(fn3); alu_v = 1; wb = 1; end
            7'b0000011: begin asrc = 1; imm_v = 1; alu_v = 1; ld = 1; res = 2'b01; end
            7'b0100011: begin asrc = 1; imm = 3'b001; imm_v = 1; alu_v = 1; st = 1; end
            7'b1100011: begin
                alu = 3'b001; imm = 3'b010; imm_v = 1; alu_v = 1;
                pcw = ((fn3 == 3'b000) && eq) || ((fn3 == 3'b001) && !eq);
            end
            7'b1101111: begin imm = 3'b011; imm_v = 1; pcw = 1; wb = 1; res = 2'b10; end
            7'b0110111: begin imm = 3'b100; imm_v = 1; wb = 1; res = 2'b11; end
            default: ;
        endcase
        for (int i = 0; i < fwait; i++)
            push(0, eq, w, rec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_BASE | M_PCS, $sformatf("%s c%0d", nm, c++));
        push(1, eq, w, rec(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0), M_BASE | M_PCS, $sformatf("%s c%0d", nm, c++));
        push(0, eq, w, rec(1, 0, 0, 0, 0, 0, 0, 0, 0, imm, 0), M_BASE | (imm_v ? M_IMM : '0),
             $sformatf("%s c%0d", nm, c++));
        push(0, eq, w, rec(2, 0, 0, 0, pcw, pcw, 0, alu, asrc, imm, 0),
             M_BASE | (imm_v ? M_IMM : '0) | (alu_v ? (M_ALU | M_ASRC) : '0) | (pcw ? M_PCS : '0),
             $sformatf("%s c%0d", nm, c++));
        if (ld || st) begin
            for (int i = 0; i < mwait && i < MAX_WAIT; i++)
                push(0, eq, w, rec(3, 1, st, 0, 0, 0, 0, 0, 0, 0, 0), M_BASE, $sformatf("%s c%0d", nm, c++));
            if (stop_mem) return;
            if (mwait >= MAX_WAIT) begin
                tmo_exp = 1'b1;
                push(0, eq, w, rec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_BASE, $sformatf("%s tmo c%0d", nm, c++));
                return;
            end
            push(1, eq, w, rec(3, 1, st, 0, 0, 0, 0, 0, 0, 0, 0), M_BASE, $sformatf("%s c%0d", nm, c++));
            wb = ld;
        end
        if (wb)
            push(0, eq, w, rec(4, 0, 0, 0, 0, 0, 1, 0, 0, 0, res), M_BASE | M_RES, $sformatf("%s c%0d", nm, c++));
    endtask

    task automatic drain();
        step_t s;
        string t;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            t = tag_q.pop_front();
            mem_ready = s.rdy;
            EQ = s.eq;
            instr = s.ins;
            #2;
            check_eq(t, 32'(pack_outputs() & s.msk), 32'(s.exp & s.msk));
            @(negedge clk);
        end
    endtask

    initial begin
        #7;
        check_eq("reset", 32'(pack_outputs()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        gen_instr("addi", 32'h00500093, 0, 0, 0, 0);
        gen_instr("sub",  32'h402081B3, 0, 2, 0, 0);
        gen_instr("or",   32'h0020E1B3, 0, 0, 0, 0);
        gen_instr("srli", 32'h0020D093, 0, 0, 0, 0);
        gen_instr("bne_t", 32'h00209463, 0, 0, 0, 0);
        gen_instr("bne_nt", 32'h00209463, 1, 0, 0, 0);
        gen_instr("beq_t", 32'h00208463, 1, 0, 0, 0);
        gen_instr("blt_nt", 32'h0020C463, 0, 0, 0, 0);
        gen_instr("jal",  32'h008000EF, 0, 0, 0, 0);
        gen_instr("lui",  32'h123450B7, 0, 0, 0, 0);
        gen_instr("lw_w3", 32'h0000A103, 0, 0, 3, 0);
        gen_instr("lw_w14", 32'h0000A103, 0, 0, MAX_WAIT - 1, 0);
        gen_instr("sw", 32'h0020A023, 0, 1, 0, 0);
`ifndef ILLEGAL_TRAP_EN
        gen_instr("ill", 32'h0000007F, 0, 0, 0, 0);
        gen_instr("addi_after_ill", 32'h00500093, 0, 0, 0, 0);
`endif
        drain();

        gen_instr("sw_tmo", 32'h0020A023, 0, 0, MAX_WAIT, 0);
        gen_instr("addi_sticky", 32'h00500093, 0, 0, 0, 0);
        drain();

        gen_instr("lw_rst", 32'h0000A103, 0, 0, 2, 1);
        drain();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #2;
        check_eq("rst_mid_mem", 32'(pack_outputs()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check_eq("rst_release", 32'(pack_outputs()), 32'(19'b000_1_0_0_0_0_0_000_0_000_00_0));
        @(negedge clk);
        tmo_exp = 1'b0;
        gen_instr("addi_post_rst", 32'h00500093, 0, 0, 0, 0);
`ifdef ILLEGAL_TRAP_EN
        gen_instr("ill", 32'h0000007F, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            push(1, 0, 32'h0000007F, rec(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_BASE | M_PCS, $sformatf("trap h%0d", i));
`endif
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
